// File: rtl/sam_pkg.sv
// Shared trace definitions: frame constants, record layout and serializer states.
package sam_pkg;

  localparam logic [7:0]  TRACE_HDR         = 8'hA5;
  localparam int unsigned TRACE_FRAME_BYTES = 9;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] wb;
  } trace_rec_t;

  typedef enum logic {S_IDLE, S_SEND} ser_state_t;

  // Byte idx of a frame: 0 is the header, then NPC and WB_OUT most-significant byte first.
  function automatic logic [7:0] trace_byte(input trace_rec_t rec, input logic [3:0] idx,
                                            input logic [7:0] hdr);
    logic [7:0] b;
    b = hdr;
    case (idx)
      4'd1: b = rec.npc[31:24];
      4'd2: b = rec.npc[23:16];
      4'd3: b = rec.npc[15:8];
      4'd4: b = rec.npc[7:0];
      4'd5: b = rec.wb[31:24];
      4'd6: b = rec.wb[23:16];
      4'd7: b = rec.wb[15:8];
      4'd8: b = rec.wb[7:0];
      default: b = hdr;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sam_sync_fifo.sv
// Single-clock FIFO with registered occupancy; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
module sam_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     RN,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  assign full  = (r_level == (AW+1)'(DEPTH));
  assign empty = (r_level == '0);
  assign level = r_level;
  assign dout  = r_mem[r_rd_ptr];

  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/sam_wb_trace.sv
// Commit-trace capture: records {NPC, WB_OUT} on every NPC change and streams
// each record as a 9-byte framed sequence over valid/ready.
module sam_wb_trace
  import sam_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter logic [7:0]  HDR   = TRACE_HDR
) (
  input  logic                   clk,
  input  logic                   RN,
  input  logic [31:0]            NPC,
  input  logic [31:0]            WB_OUT,
  input  logic                   en,
  input  logic                   tx_ready,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [15:0]            overflow_cnt
);

  localparam logic [3:0] LAST_IDX = 4'(TRACE_FRAME_BYTES - 1);

  logic [31:0] r_prev_npc;
  logic [15:0] r_ovf;
  logic        w_cap;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  trace_rec_t  w_din;
  trace_rec_t  w_dout;

  ser_state_t  r_state, w_state_nx;
  logic [3:0]  r_idx, w_idx_nx;
  logic        r_valid, w_valid_nx;
  logic [7:0]  r_data, w_data_nx;
  trace_rec_t  r_rec, w_rec_nx;

  // prev_npc tracks NPC even while disabled so re-enabling never fires on a stale value.
  assign w_cap  = en && (NPC != r_prev_npc);
  assign w_push = w_cap && (!w_full || w_pop);
  assign w_din  = '{npc: NPC, wb: WB_OUT};

  sam_sync_fifo #(
    .WIDTH ($bits(trace_rec_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .RN    (RN),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_prev_npc <= '1;
      r_ovf      <= '0;
    end else begin
      r_prev_npc <= NPC;
      if (w_cap && w_full && !w_pop && (r_ovf != '1)) r_ovf <= r_ovf + 16'd1;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_valid_nx = r_valid;
    w_data_nx  = r_data;
    w_rec_nx   = r_rec;
    w_pop      = 1'b0;
    case (r_state)
      S_IDLE: w_pop = !w_empty;
      S_SEND: begin
        if (r_valid && tx_ready) begin
          if (r_idx == LAST_IDX) begin
            if (!w_empty) begin
              w_pop = 1'b1;
            end else begin
              w_state_nx = S_IDLE;
              w_valid_nx = 1'b0;
            end
          end else begin
            w_idx_nx  = r_idx + 4'd1;
            w_data_nx = trace_byte(r_rec, r_idx + 4'd1, HDR);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // A pop always starts a fresh frame, whether from idle or straight after the last byte.
    if (w_pop) begin
      w_state_nx = S_SEND;
      w_idx_nx   = '0;
      w_valid_nx = 1'b1;
      w_data_nx  = HDR;
      w_rec_nx   = w_dout;
    end
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_rec   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_valid <= w_valid_nx;
      r_data  <= w_data_nx;
      r_rec   <= w_rec_nx;
    end
  end

  assign tx_valid     = r_valid;
  assign tx_data      = r_data;
  assign overflow_cnt = r_ovf;

endmodule

// File: tb/tb_sam_wb_trace.sv
// Directed and randomized checks of sam_wb_trace against a queue-based frame model.
module tb_sam_wb_trace;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        RN;
  logic [31:0] NPC;
  logic [31:0] WB_OUT;
  logic        en;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [3:0]  fifo_level;
  logic [15:0] overflow_cnt;

  always #5 clk = ~clk;

  sam_wb_trace #(.DEPTH(DEPTH), .HDR(8'hA5)) dut (
    .clk          (clk),
    .RN           (RN),
    .NPC          (NPC),
    .WB_OUT       (WB_OUT),
    .en           (en),
    .tx_ready     (tx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .fifo_level   (fifo_level),
    .overflow_cnt (overflow_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Model: pending records, record being sent, bytes of it still to go, drop count.
  logic [63:0] m_q[$];
  logic [63:0] m_cur;
  int          m_left;
  int          m_ovf;
  logic [31:0] m_prev;

  logic [7:0] single_exp [9] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78};
  logic       bp_pat [12]    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [63:0] rec, input int i);
    logic [71:0] fr;
    fr = {8'hA5, rec};
    return fr[71-8*i -: 8];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur  = '0;
    m_left = 0;
    m_ovf  = 0;
    m_prev = '1;
  endtask

  task automatic model_edge();
    if (m_left > 0 && tx_ready) m_left--;
    if (m_left == 0 && m_q.size() > 0) begin
      m_cur  = m_q.pop_front();
      m_left = 9;
    end
    if (en && NPC != m_prev) begin
      if (m_q.size() < DEPTH) m_q.push_back({NPC, WB_OUT});
      else if (m_ovf < 65535) m_ovf++;
    end
    m_prev = NPC;
  endtask

  task automatic compare_outputs();
    check("tx_valid", tx_valid, m_left > 0);
    if (m_left > 0) check("tx_data", tx_data, exp_byte(m_cur, 9 - m_left));
    check("fifo_level", fifo_level, m_q.size());
    check("overflow_cnt", overflow_cnt, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  initial begin
    int run;
    int max_run;
    int thr;

    RN = 1'b0; en = 1'b0; tx_ready = 1'b0; NPC = '0; WB_OUT = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow_cnt, 0);
    RN = 1'b1;

    // First NPC after reset is a commit even though it is zero.
    en = 1'b1; tx_ready = 1'b1; NPC = 32'h0; WB_OUT = 32'hAAAA_0000;
    cycle();
    check("first_cap_level", fifo_level, 1);
    repeat (11) cycle();

    // Single commit frame with ready held high.
    NPC = 32'h4; WB_OUT = 32'h1234_5678;
    cycle();
    check("cap_edge_valid", tx_valid, 0);
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("single_valid", tx_valid, 1);
      check("single_byte", tx_data, single_exp[i]);
    end
    cycle();
    check("single_end_valid", tx_valid, 0);

    // Backpressure inside a frame.
    NPC = 32'h8; WB_OUT = 32'hDEAD_BEEF;
    cycle();
    for (int i = 0; i < 12; i++) begin
      tx_ready = bp_pat[i];
      cycle();
    end
    tx_ready = 1'b1;
    repeat (8) cycle();

    // Overflow: serializer stalled on a filler frame, then 11 commits.
    tx_ready = 1'b0; NPC = 32'h200; WB_OUT = 32'h0F0F_0F0F;
    cycle();
    cycle();
    for (int k = 0; k < 11; k++) begin
      NPC = 32'h300 + 32'(4 * k); WB_OUT = $urandom;
      cycle();
    end
    check("ovf_level", fifo_level, 8);
    check("ovf_cnt", overflow_cnt, 3);
    tx_ready = 1'b1;
    repeat (90) cycle();
    check("ovf_drained", fifo_level, 0);

    // Enable gating.
    en = 1'b0;
    NPC = 32'h10; cycle();
    NPC = 32'h14; cycle();
    NPC = 32'h18; cycle();
    en = 1'b1;
    cycle();
    cycle();
    check("en_gate_level", fifo_level, 0);
    check("en_gate_valid", tx_valid, 0);
    NPC = 32'h1C; WB_OUT = 32'h5555_AAAA;
    cycle();
    check("en_recap_level", fifo_level, 1);
    repeat (11) cycle();

    // Back-to-back frames.
    NPC = 32'h20; WB_OUT = $urandom; cycle();
    NPC = 32'h24; WB_OUT = $urandom; cycle();
    run = tx_valid ? 1 : 0;
    max_run = run;
    repeat (22) begin
      cycle();
      run = tx_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    check("b2b_run", max_run, 18);

    // Push and pop on the same edge while full.
    tx_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      NPC = 32'h400 + 32'(4 * k); WB_OUT = $urandom;
      cycle();
    end
    check("full_level", fifo_level, 8);
    tx_ready = 1'b1;
    repeat (8) cycle();
    check("pre_pushpop_level", fifo_level, 8);
    NPC = 32'h500; WB_OUT = $urandom;
    cycle();
    check("pushpop_level", fifo_level, 8);
    check("pushpop_ovf", overflow_cnt, 3);
    repeat (90) cycle();

    // Asynchronous reset in the middle of a frame.
    NPC = 32'h600; WB_OUT = $urandom;
    cycle(); cycle(); cycle();
    #2 RN = 1'b0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_level", fifo_level, 0);
    check("midrst_ovf", overflow_cnt, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 RN = 1'b1;
    NPC = 32'h0; WB_OUT = 32'h0000_0042;
    cycle();
    check("postrst_cap_level", fifo_level, 1);
    cycle();
    check("postrst_valid", tx_valid, 1);
    check("postrst_hdr", tx_data, 8'hA5);

    // Randomized traffic with varying commit rate and sink readiness.
    for (int blk = 0; blk < 8; blk++) begin
      thr = $urandom_range(2, 16);
      for (int c = 0; c < 500; c++) begin
        en       = ($urandom_range(0, 9) != 0);
        tx_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, thr - 1) == 0) NPC = $urandom;
        WB_OUT = $urandom;
        cycle();
      end
    end
    tx_ready = 1'b1;
    repeat (100) cycle();
    check("final_level", fifo_level, 0);
    check("final_valid", tx_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
